// File: rtl/johnson_decoder_8bit.sv
// johnson_decoder_8bit: decodes sampled 8-bit Johnson counter words into a 0..15 position
// and tracks whether successive samples follow the counting sequence.
module johnson_decoder_8bit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [3:0] index,
    output logic       index_valid,
    output logic       illegal_code,
    output logic       seq_error,
    output logic       locked,
    output logic [7:0] wrap_count,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
    state_t state, state_nxt;
    logic [3:0] pop, dec_index, index_nxt;
    logic [2:0] edges;
    logic       legal, in_order, take, seq_nxt, ill_nxt, wrap_evt;
    logic [7:0] wrap_nxt, err_nxt;
    always_comb begin
        pop   = '0;
        edges = '0;
        for (int i = 0; i < 8; i++) pop += {3'b0, code_in[i]};
        for (int i = 0; i < 7; i++) edges += {2'b0, code_in[i] ^ code_in[i+1]};
    end
    // A Johnson word has at most one boundary between its run of ones and run of zeros.
    assign legal     = edges <= 3'd1;
    assign dec_index = (code_in[7] || code_in == 8'h00) ? pop : 4'd0 - pop;
    assign in_order  = dec_index == index + 4'd1;
    assign take      = code_valid && legal;
    always_comb begin
        state_nxt = !code_valid ? state
                  : !legal ? UNLOCKED
                  : (state != UNLOCKED && in_order) ? LOCKED : ACQUIRE;
        index_nxt = take ? dec_index : index;
        ill_nxt   = code_valid && !legal;
        seq_nxt   = take && state == LOCKED && !in_order;
        wrap_evt  = take && state == LOCKED && in_order && index == 4'd15;
        wrap_nxt  = (wrap_evt && wrap_count != 8'hFF) ? wrap_count + 8'd1 : wrap_count;
        err_nxt   = ((ill_nxt || seq_nxt) && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= UNLOCKED;
            index        <= '0;
            index_valid  <= 1'b0;
            illegal_code <= 1'b0;
            seq_error    <= 1'b0;
            wrap_count   <= '0;
            err_count    <= '0;
        end else begin
            state        <= state_nxt;
            index        <= index_nxt;
            index_valid  <= take;
            illegal_code <= ill_nxt;
            seq_error    <= seq_nxt;
            wrap_count   <= wrap_nxt;
            err_count    <= err_nxt;
        end
    end
    assign locked = state == LOCKED;
endmodule

// File: tb/tb_johnson_decoder_8bit.sv
// tb_johnson_decoder_8bit: directed vectors with a queued scoreboard checked by a separate monitor.
module tb_johnson_decoder_8bit;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] code_in;
    logic       code_valid;
    logic [3:0] index;
    logic       index_valid, illegal_code, seq_error, locked;
    logic [7:0] wrap_count, err_count;
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] idx;
        logic       iv, ill, se, lk;
        logic [7:0] wr, er;
    } exp_t;
    exp_t q[$];

    johnson_decoder_8bit dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .index(index), .index_valid(index_valid), .illegal_code(illegal_code),
        .seq_error(seq_error), .locked(locked), .wrap_count(wrap_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Johnson words in counting order; position k decodes to index k.
    logic [7:0] jc [16] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                            8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    always @(negedge clk) begin
        exp_t act, e;
        if (!reset && (index_valid || illegal_code || seq_error)) begin
            act = '{index, index_valid, illegal_code, seq_error, locked, wrap_count, err_count};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", act);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL sample t=%0t actual idx=%0d iv=%b ill=%b se=%b lk=%b wr=%0d er=%0d required idx=%0d iv=%b ill=%b se=%b lk=%b wr=%0d er=%0d",
                             $time, act.idx, act.iv, act.ill, act.se, act.lk, act.wr, act.er,
                             e.idx, e.iv, e.ill, e.se, e.lk, e.wr, e.er);
                end
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [3:0] ei, input logic eiv, eill, ese, elk,
                        input logic [7:0] ew, ee);
        @(negedge clk);
        code_in = c;
        code_valid = 1'b1;
        q.push_back('{ei, eiv, eill, ese, elk, ew, ee});
    endtask

    task automatic drain();
        @(negedge clk);
        code_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) break;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({index, index_valid, illegal_code, seq_error, locked, wrap_count, err_count} !== 24'h0) begin
            failures++;
            $display("FAIL %s_outputs actual=%h required=000000", name,
                     {index, index_valid, illegal_code, seq_error, locked, wrap_count, err_count});
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL %s_locked actual=%b required=0", name, locked);
        end
    endtask

    initial begin
        reset = 1'b1;
        code_in = 8'h00;
        code_valid = 1'b0;
        #14;
        check_reset("reset_initial");
        #2;
        reset = 1'b0;

        // Full counting sequence plus wrap back to zero.
        for (int k = 0; k < 16; k++)
            send(jc[k], 4'(k), 1'b1, 1'b0, 1'b0, k != 0, 8'd0, 8'd0);
        send(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);

        // Illegal word while locked at index 2.
        send(8'h80, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
        send(8'hC0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
        send(8'hA0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);

        // Relock, then jump out of order and reacquire.
        send(8'h80, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
        send(8'hC0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
        send(8'hF0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        send(8'hF8, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2);
        drain();

        // Reset while locked discards lock and counters.
        reset = 1'b1;
        #14;
        check_reset("reset_mid");
        #1;
        reset = 1'b0;
        send(8'h80, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

        // Error counter saturation.
        for (int k = 0; k < 300; k++)
            send(8'hA0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, (k >= 254) ? 8'd255 : 8'(k + 1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
